// File: rtl/or_gate_1_pkg.sv
// Shared defaults and small helpers for the or_gate_1 library cell.
// Holds no state and adds no logic of its own.
package or_gate_1_pkg;

   localparam int unsigned OR_WIDTH_DEF = 1;
   localparam int unsigned OR_CNT_W_DEF = 8;

   // A rising edge is seen as "high now, low on the previous cycle".
   function automatic logic rise_det(input logic cur, input logic prev);
      return cur & ~prev;
   endfunction

endpackage

// File: rtl/or_gate_1_sat_counter.sv
// Saturating up-counter: adds one on each enabled clk edge and sticks at all-ones.
// Only reset clears it. The count is registered, so it is visible one edge after the enable is sampled.
module or_gate_1_sat_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/or_gate_1.sv
// Bitwise OR cell with a combinational result, a registered copy, an any-high flag, a rise pulse and a cycle counter.
// Q has zero latency, Q_reg/Q_any one cycle, rise_pulse two cycles. There is no flow control.
module or_gate_1
   import or_gate_1_pkg::*;
#(
   parameter int unsigned WIDTH = OR_WIDTH_DEF,
   parameter int unsigned CNT_W = OR_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Q_reg,
   output logic             Q_any,
   output logic             rise_pulse,
   output logic [CNT_W-1:0] hi_count
);

   logic [WIDTH-1:0] q_reg_q;
   logic [WIDTH-1:0] q_reg_d;
   logic             prev_q;
   logic             prev_d;
   logic             rise_q;
   logic             rise_d;
   logic             q_any;

   // Q is kept clear of clk/rst_n so the cell still works as a plain OR when it is left unclocked.
   assign Q     = A | B;
   assign q_any = |q_reg_q;

   always_comb begin
      q_reg_d = Q;
      prev_d  = q_any;
      rise_d  = rise_det(q_any, prev_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_reg_q <= '0;
         prev_q  <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         q_reg_q <= q_reg_d;
         prev_q  <= prev_d;
         rise_q  <= rise_d;
      end
   end

   or_gate_1_sat_counter #(
      .CNT_W (CNT_W)
   ) u_hi_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (q_any),
      .cnt_o (hi_count)
   );

   assign Q_reg      = q_reg_q;
   assign Q_any      = q_any;
   assign rise_pulse = rise_q;

endmodule

// File: tb/tb_or_gate_1.sv
// Bench for or_gate_1: a clocked WIDTH=4/CNT_W=3 instance is checked against a sample-history model,
// and an unclocked WIDTH=1 instance is checked as a pure OR.
module tb_or_gate_1;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] a4    = '0;
   logic [3:0] b4    = '0;
   logic [3:0] q4;
   logic [3:0] q4_reg;
   logic       q4_any;
   logic       q4_rise;
   logic [2:0] q4_cnt;

   logic       a1 = 1'b0;
   logic       b1 = 1'b0;
   logic       q1;
   logic       q1_reg;
   logic       q1_any;
   logic       q1_rise;
   logic [7:0] q1_cnt;
   wire        clk_nc  = 1'bz;
   wire        rstn_nc = 1'bz;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   or_gate_1 #(.WIDTH(4), .CNT_W(3)) dut4 (
      .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .Q(q4), .Q_reg(q4_reg),
      .Q_any(q4_any), .rise_pulse(q4_rise), .hi_count(q4_cnt)
   );

   or_gate_1 dut1 (
      .clk(clk_nc), .rst_n(rstn_nc), .A(a1), .B(b1), .Q(q1), .Q_reg(q1_reg),
      .Q_any(q1_any), .rise_pulse(q1_rise), .hi_count(q1_cnt)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Model: every OR value sampled since the last reset, oldest first.
   logic [3:0] hist[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) hist.delete();
      else        hist.push_back(a4 | b4);
   end

   always @(negedge clk) begin
      int         n;
      int         cnt;
      logic [3:0] e_reg;
      logic       e_rise;
      if (chk_en) begin
         n      = hist.size();
         e_reg  = (n >= 1) ? hist[n-1] : 4'h0;
         e_rise = (n >= 2) && (hist[n-2] != 0) && ((n < 3) || (hist[n-3] == 0));
         cnt    = 0;
         for (int i = 0; i < n - 1; i++) if (hist[i] != 0) cnt++;
         if (cnt > 7) cnt = 7;
         check("m_q",     q4,      a4 | b4);
         check("m_q_reg", q4_reg,  e_reg);
         check("m_q_any", q4_any,  e_reg != 0);
         check("m_rise",  q4_rise, e_rise);
         check("m_cnt",   q4_cnt,  cnt);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic at_neg();
      @(negedge clk);
      #1;
   endtask

   int         sat_exp[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 7};
   logic [3:0] vec_a[12]   = '{4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'hF, 4'h0, 4'h0, 4'h5, 4'h0};
   logic [3:0] vec_b[12]   = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'hA, 4'h0};
   logic       tbl_a[9]    = '{0, 0, 1, 1, 0, 1, 0, 1, 0};
   logic       tbl_b[9]    = '{0, 1, 0, 1, 0, 0, 1, 1, 0};
   logic       tbl_q[9]    = '{0, 1, 1, 1, 0, 1, 1, 1, 0};

   initial begin
      // Reset state: a clock edge with rst_n low.
      @(posedge clk);
      #1;
      check("rst_q_reg", q4_reg,  4'h0);
      check("rst_q_any", q4_any,  1'b0);
      check("rst_rise",  q4_rise, 1'b0);
      check("rst_cnt",   q4_cnt,  3'd0);
      chk_en = 1'b1;
      step();
      rst_n = 1'b1;

      // Rise pulse: two quiet cycles, then B=1 and hold it.
      repeat (2) step();
      b4 = 4'b0001;
      step();
      at_neg();
      check("edge_q_reg", q4_reg,  4'b0001);
      check("edge_rise0", q4_rise, 1'b0);
      step();
      at_neg();
      check("edge_rise1", q4_rise, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step();
         at_neg();
         check("edge_hold", q4_rise, 1'b0);
      end
      check("edge_cnt", q4_cnt, 3'd5);

      // Multi-bit OR values and the Q_any latency.
      a4 = 4'b1010; b4 = 4'b0101;
      #1 check("w4_q_1111", q4, 4'b1111);
      a4 = 4'b0000; b4 = 4'b0000;
      repeat (2) step();
      a4 = 4'b1000;
      #1 check("w4_q_1000", q4, 4'b1000);
      check("w4_any_pre", q4_any, 1'b0);
      step();
      at_neg();
      check("w4_any_post", q4_any, 1'b1);
      check("w4_q_reg",    q4_reg, 4'b1000);

      // Async reset mid-cycle with A=B=1.
      a4 = 4'b0001; b4 = 4'b0001;
      repeat (3) step();
      #1 rst_n = 1'b0;
      #1;
      check("arst_q_reg", q4_reg,  4'h0);
      check("arst_q_any", q4_any,  1'b0);
      check("arst_rise",  q4_rise, 1'b0);
      check("arst_cnt",   q4_cnt,  3'd0);
      check("arst_q",     q4,      4'b0001);
      step();

      // Saturation of the 3-bit counter with A=1 held.
      b4 = 4'b0000;
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         at_neg();
         check("sat_cnt", q4_cnt, sat_exp[k]);
      end

      // Directed vectors for the model, including repeated rise edges.
      for (int i = 0; i < 12; i++) begin
         a4 = vec_a[i];
         b4 = vec_b[i];
         step();
      end
      at_neg();
      chk_en = 1'b0;

      // Unclocked WIDTH=1 instance acting as a plain OR gate.
      for (int i = 0; i < 9; i++) begin
         a1 = tbl_a[i];
         b1 = tbl_b[i];
         #5;
         check("comb_q", q1, tbl_q[i]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
